// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port, shared memory port and status.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface mem_arbiter_if #(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32
);
   // fetch port
   logic                 if_req;
   logic [AddrWidth-1:0] if_addr;
   logic [DataWidth-1:0] if_rdata;
   logic                 if_ready;
   // data port
   logic                 dm_req;
   logic                 dm_we;
   logic [AddrWidth-1:0] dm_addr;
   logic [DataWidth-1:0] dm_wdata;
   logic [DataWidth-1:0] dm_rdata;
   logic                 dm_ready;
   // shared memory port
   logic                 mem_en;
   logic                 mem_we;
   logic [AddrWidth-1:0] mem_addr;
   logic [DataWidth-1:0] mem_wdata;
   logic [DataWidth-1:0] mem_rdata;
   // status
   logic                 busy;
   logic                 owner;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_rdata, if_ready, dm_rdata, dm_ready,
             mem_en, mem_we, mem_addr, mem_wdata, busy, owner
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_rdata, if_ready, dm_rdata, dm_ready,
             mem_en, mem_we, mem_addr, mem_wdata, busy, owner
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port memory with fixed latency.
// Contention alternates between ports, starting with the data port after reset.
module mem_arbiter #(
   parameter int AddrWidth  = 32,
   parameter int DataWidth  = 32,
   parameter int MemLatency = 2
) (
   input logic           clk,
   input logic           reset,
   mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   localparam logic [3:0] LastCnt = 4'(MemLatency - 1);

   state_t               state;
   logic [3:0]           cnt;
   logic                 last_was_data;
   logic                 grant_data;

   logic                 mem_en_q;
   logic                 mem_we_q;
   logic [AddrWidth-1:0] mem_addr_q;
   logic [DataWidth-1:0] mem_wdata_q;
   logic                 if_ready_q;
   logic                 dm_ready_q;
   logic [DataWidth-1:0] if_rdata_q;
   logic [DataWidth-1:0] dm_rdata_q;
   logic                 busy_q;
   logic                 owner_q;

   // Pick the data port when it alone requests, or on a tie when fetch won last time.
   always_comb begin
      grant_data = bus.dm_req & (~bus.if_req | ~last_was_data);
   end

   // Arbitration FSM; every output is a register updated here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         last_was_data <= 1'b0;
         mem_en_q      <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         if_ready_q    <= 1'b0;
         dm_ready_q    <= 1'b0;
         if_rdata_q    <= '0;
         dm_rdata_q    <= '0;
         busy_q        <= 1'b0;
         owner_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.if_req || bus.dm_req) begin
                  state         <= ACCESS;
                  cnt           <= '0;
                  busy_q        <= 1'b1;
                  mem_en_q      <= 1'b1;
                  owner_q       <= grant_data;
                  last_was_data <= grant_data;
                  if (grant_data) begin
                     mem_addr_q  <= bus.dm_addr;
                     mem_wdata_q <= bus.dm_wdata;
                     mem_we_q    <= bus.dm_we;
                  end else begin
                     mem_addr_q  <= bus.if_addr;
                     mem_wdata_q <= '0;
                     mem_we_q    <= 1'b0;
                  end
               end
            end
            ACCESS: begin
               cnt <= cnt + 4'd1;
               if (cnt == LastCnt) begin
                  state    <= DONE;
                  mem_en_q <= 1'b0;
                  mem_we_q <= 1'b0;
                  // mem_we_q still holds the access type here (non-blocking update above)
                  if (owner_q) begin
                     dm_ready_q <= 1'b1;
                     if (!mem_we_q) dm_rdata_q <= bus.mem_rdata;
                  end else begin
                     if_ready_q <= 1'b1;
                     if_rdata_q <= bus.mem_rdata;
                  end
               end
            end
            DONE: begin
               if_ready_q <= 1'b0;
               dm_ready_q <= 1'b0;
               busy_q     <= 1'b0;
               state      <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_ready  = if_ready_q;
   assign bus.dm_ready  = dm_ready_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.busy      = busy_q;
   assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts each grant
// (cycle, port, latched request) and the readback values; a monitor checks the bus.
module tb_mem_arbiter;

   localparam int L = 2;

   typedef struct {
      int          grant;
      bit          port;
      logic [31:0] addr;
      bit          we;
      logic [31:0] wdata;
      logic [31:0] rif;
      logic [31:0] rdm;
   } txn_t;

   logic clk;
   logic reset;

   mem_arbiter_if #(.AddrWidth(32), .DataWidth(32)) bus ();

   mem_arbiter #(.AddrWidth(32), .DataWidth(32), .MemLatency(L)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   tests_run = 0;
   int   tests_failed = 0;
   int   edge_n = 0;
   txn_t q[$];

   // model state
   int          next_free = 0;
   bit          lwd = 1'b0;
   logic [31:0] m_if = '0;
   logic [31:0] m_dm = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      if (a == 32'h10) return 32'hDEADBEEF;
      return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
   endfunction

   assign bus.mem_rdata = memfn(bus.mem_addr);

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_n);
      end
   endtask

   // Drive one cycle of inputs (seen by the next rising edge) and update the model.
   task automatic step(input bit r, input bit ifr, input logic [31:0] ifa, input bit dmr,
                       input bit dwe, input logic [31:0] dma, input logic [31:0] dwd);
      txn_t t;
      @(posedge clk);
      edge_n++;
      #1;
      reset        = r;
      bus.if_req   = ifr;
      bus.if_addr  = ifa;
      bus.dm_req   = dmr;
      bus.dm_we    = dwe;
      bus.dm_addr  = dma;
      bus.dm_wdata = dwd;
      if (r) begin
         q.delete();
         lwd       = 1'b0;
         m_if      = '0;
         m_dm      = '0;
         next_free = 0;
      end else if ((ifr || dmr) && (edge_n + 1 >= next_free)) begin
         t.grant = edge_n + 1;
         t.port  = dmr && (!ifr || !lwd);
         if (t.port) begin
            t.addr  = dma;
            t.we    = dwe;
            t.wdata = dwd;
            if (!dwe) m_dm = memfn(dma);
         end else begin
            t.addr  = ifa;
            t.we    = 1'b0;
            t.wdata = '0;
            m_if    = memfn(ifa);
         end
         t.rif     = m_if;
         t.rdm     = m_dm;
         lwd       = t.port;
         next_free = t.grant + L + 2;
         q.push_back(t);
      end
   endtask

   // Monitor: compare memory side, readies, status and readback against the queue head.
   always @(negedge clk) begin : mon
      bit   have;
      bit   in_acc;
      bit   at_rdy;
      txn_t f;
      if (!reset) begin
         have = (q.size() != 0);
         if (have) f = q[0];
         in_acc = have && (edge_n >= f.grant) && (edge_n < f.grant + L);
         at_rdy = have && (edge_n == f.grant + L);
         chk("mem_en", 64'(bus.mem_en), 64'(in_acc));
         chk("busy", 64'(bus.busy), 64'(have && (edge_n >= f.grant)));
         chk("ready_overlap", 64'(bus.if_ready & bus.dm_ready), 64'(0));
         if (in_acc) begin
            chk("mem_addr", 64'(bus.mem_addr), 64'(f.addr));
            chk("mem_we", 64'(bus.mem_we), 64'(f.we));
            chk("owner", 64'(bus.owner), 64'(f.port));
            if (f.we) chk("mem_wdata", 64'(bus.mem_wdata), 64'(f.wdata));
         end
         chk("if_ready", 64'(bus.if_ready), 64'(at_rdy && !f.port));
         chk("dm_ready", 64'(bus.dm_ready), 64'(at_rdy && f.port));
         if (at_rdy) begin
            chk("if_rdata", 64'(bus.if_rdata), 64'(f.rif));
            chk("dm_rdata", 64'(bus.dm_rdata), 64'(f.rdm));
            void'(q.pop_front());
         end
      end
   end

   initial begin
      reset        = 1'b1;
      bus.if_req   = 1'b0;
      bus.if_addr  = '0;
      bus.dm_req   = 1'b0;
      bus.dm_we    = 1'b0;
      bus.dm_addr  = '0;
      bus.dm_wdata = '0;

      // reset state
      repeat (3) step(1, 0, 0, 0, 0, 0, 0);
      #1;
      chk("rst_mem_en", 64'(bus.mem_en), 0);
      chk("rst_mem_we", 64'(bus.mem_we), 0);
      chk("rst_mem_addr", 64'(bus.mem_addr), 0);
      chk("rst_mem_wdata", 64'(bus.mem_wdata), 0);
      chk("rst_if_ready", 64'(bus.if_ready), 0);
      chk("rst_dm_ready", 64'(bus.dm_ready), 0);
      chk("rst_if_rdata", 64'(bus.if_rdata), 0);
      chk("rst_dm_rdata", 64'(bus.dm_rdata), 0);
      chk("rst_busy", 64'(bus.busy), 0);
      chk("rst_owner", 64'(bus.owner), 0);

      // single fetch at 0x10
      step(0, 1, 32'h10, 0, 0, 0, 0);
      repeat (6) step(0, 0, 0, 0, 0, 0, 0);

      // data write then data read at 0x40
      step(0, 0, 0, 1, 1, 32'h40, 32'h12345678);
      repeat (6) step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 32'h40, 32'h0);
      repeat (6) step(0, 0, 0, 0, 0, 0, 0);

      // contention from reset: data, fetch, data, fetch
      step(1, 0, 0, 0, 0, 0, 0);
      repeat (17) step(0, 1, 32'h100, 1, 0, 32'h200, 32'h0);
      repeat (6) step(0, 0, 0, 0, 0, 0, 0);

      // mid-access change of fetch address and request
      step(0, 1, 32'h10, 0, 0, 0, 0);
      step(0, 0, 32'h20, 0, 0, 0, 0);
      repeat (6) step(0, 0, 0, 0, 0, 0, 0);

      // reset during the first ACCESS cycle of a read
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 32'h10, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      #1;
      chk("rst_abort_mem_en", 64'(bus.mem_en), 0);
      chk("rst_abort_if_rdata", 64'(bus.if_rdata), 0);
      chk("rst_abort_if_ready", 64'(bus.if_ready), 0);
      step(0, 1, 32'h30, 1, 0, 32'h50, 0);
      repeat (8) step(0, 1, 32'h30, 1, 0, 32'h50, 0);
      repeat (6) step(0, 0, 0, 0, 0, 0, 0);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         step(($urandom % 151) == 0,
              ($urandom % 3) != 0, $urandom,
              ($urandom % 3) != 0, $urandom % 2, $urandom, $urandom);
      end

      // drain
      repeat (L + 6) step(0, 0, 0, 0, 0, 0, 0);
      chk("drain_empty", 64'(q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
